// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART transmitter and the
//               future receiver: state encoding, parity modes, default divider.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Frame sequencer states, 3-bit encoding shared by TX and RX.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Parity mode selectors.
  localparam logic PARITY_MODE_EVEN = 1'b0;
  localparam logic PARITY_MODE_ODD  = 1'b1;

  // 100 MHz / 115200 baud = 868.06, rounded down.
  localparam int DEFAULT_CLK_DIV = 868;

  // Parity of a word of up to 9 bits (narrower words are zero-extended,
  // which does not change the XOR), inverted for odd parity.
  function automatic logic parity_bit(input logic [8:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_cnt
// Description : Bit-period divider. Counts 0..CLK_DIV-1, wraps, and flags the
//               last count of each period. A clear restarts the period.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int             CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;

  // Free-running period counter; cleared on request and on wrap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count <= '0;
    end else if (i_clr || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign o_tick = (count == LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : UART serial transmitter. Accepts words on a valid/ready
//               handshake and sends start, data (LSB first), optional parity
//               and stop bits on a registered, idle-high line.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic                  o_tx,
  output logic                  o_busy
);

  localparam int            BW        = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic          ODD_MODE  = (PARITY_ODD != 0) ? PARITY_MODE_ODD : PARITY_MODE_EVEN;

  state_t                  state;
  state_t                  next_state;
  logic [DATA_WIDTH-1:0]   shreg;
  logic [BW-1:0]           bit_cnt;
  logic                    par_bit;
  logic                    started;
  logic                    tick;
  logic                    clr;
  logic                    handshake;
  logic                    tx_next;

  assign handshake = i_valid && o_ready;
  assign o_busy    = (state != IDLE);

  uart_baud_cnt #(
    .CLK_DIV (CLK_DIV)
  ) u_baud (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (clr),
    .o_tick (tick)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; every state entry restarts the bit period.
  always_comb begin
    next_state = state;
    clr        = 1'b0;
    case (state)
      IDLE: begin
        if (handshake) begin
          next_state = START;
          clr        = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          next_state = DATA;
          clr        = 1'b1;
        end
      end
      DATA: begin
        if (tick && (bit_cnt == DATA_LAST)) begin
          next_state = (PARITY_EN != 0) ? PARITY : STOP;
          clr        = 1'b1;
        end
      end
      PARITY: begin
        if (tick) begin
          next_state = STOP;
          clr        = 1'b1;
        end
      end
      STOP: begin
        if (tick && (bit_cnt == STOP_LAST)) begin
          next_state = IDLE;
          clr        = 1'b1;
        end
      end
      default: begin
        next_state = IDLE;
        clr        = 1'b1;
      end
    endcase
  end

  // Line level for the current state; registered one cycle later onto o_tx.
  always_comb begin
    tx_next = 1'b1;
    case (state)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shreg[0];
      PARITY:  tx_next = par_bit;
      default: tx_next = 1'b1;
    endcase
  end

  // Capture the word and its parity on the handshake; shift at each data bit end.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      shreg   <= '0;
      par_bit <= 1'b0;
    end else if (handshake) begin
      shreg   <= i_data;
      par_bit <= parity_bit(9'(i_data), ODD_MODE);
    end else if ((state == DATA) && tick) begin
      shreg   <= shreg >> 1;
    end
  end

  // Bit counter for data bits and stop bits; restarts on every state entry.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bit_cnt <= '0;
    end else if (clr) begin
      bit_cnt <= '0;
    end else if (tick && ((state == DATA) || (state == STOP))) begin
      bit_cnt <= bit_cnt + BW'(1);
    end
  end

  // Registered outputs; ready is held off for one edge after reset release.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_tx    <= 1'b1;
      o_ready <= 1'b0;
      started <= 1'b0;
    end else begin
      o_tx    <= tx_next;
      o_ready <= started && (next_state == IDLE);
      started <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Self-checking bench for uart_tx. Four instances cover the
//               basic, even-parity, odd-parity and two-stop-bit configurations;
//               every line sample is compared with a frame model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

  localparam int NI = 4;
  localparam int CD    [NI] = '{4, 4, 4, 2};
  localparam int PEN   [NI] = '{0, 1, 1, 0};
  localparam int PODD  [NI] = '{0, 0, 1, 0};
  localparam int NSTOP [NI] = '{1, 1, 1, 2};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NI-1:0] vld = '0;
  logic [7:0]    din [NI];
  wire  [NI-1:0] tx;
  wire  [NI-1:0] rdy;
  wire  [NI-1:0] bsy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLK_DIV(4), .DATA_WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_basic (
    .i_clk(clk), .i_rst(rst), .i_data(din[0]), .i_valid(vld[0]),
    .o_ready(rdy[0]), .o_tx(tx[0]), .o_busy(bsy[0]));
  uart_tx #(.CLK_DIV(4), .DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_peven (
    .i_clk(clk), .i_rst(rst), .i_data(din[1]), .i_valid(vld[1]),
    .o_ready(rdy[1]), .o_tx(tx[1]), .o_busy(bsy[1]));
  uart_tx #(.CLK_DIV(4), .DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_podd (
    .i_clk(clk), .i_rst(rst), .i_data(din[2]), .i_valid(vld[2]),
    .o_ready(rdy[2]), .o_tx(tx[2]), .o_busy(bsy[2]));
  uart_tx #(.CLK_DIV(2), .DATA_WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_stop2 (
    .i_clk(clk), .i_rst(rst), .i_data(din[3]), .i_valid(vld[3]),
    .o_ready(rdy[3]), .o_tx(tx[3]), .o_busy(bsy[3]));

  // Frame model: bit position 0 is start, then data LSB first, parity, stops.
  function automatic logic expected_bit(input int idx, input logic [7:0] d, input int pos);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return d[pos-1];
    if ((PEN[idx] != 0) && (pos == 9))
      return logic'(($countones(d) % 2) != 0) ^ logic'(PODD[idx] != 0);
    return 1'b1;
  endfunction

  function automatic int frame_bits(input int idx);
    return 1 + 8 + PEN[idx] + NSTOP[idx];
  endfunction

  // Send one word on instance idx and check every line cycle of its frame.
  task automatic send(input int idx, input logic [7:0] d, input bit keep,
                      input bit change, input logic [7:0] d_late);
    int   len;
    int   w;
    int   busy_cnt;
    logic e;
    len = frame_bits(idx) * CD[idx];
    din[idx] = d;
    vld[idx] = 1'b1;
    w = 0;
    while ((rdy[idx] !== 1'b1) && (w < 100)) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (rdy[idx] !== 1'b1) begin
      errors++;
      $display("FAIL handshake_wait inst=%0d: ready=%b, required 1", idx, rdy[idx]);
      vld[idx] = 1'b0;
      return;
    end
    @(negedge clk);
    checks++;
    if (tx[idx] !== 1'b1) begin
      errors++;
      $display("FAIL tx_before_start inst=%0d: tx=%b, required 1", idx, tx[idx]);
    end
    checks++;
    if ((bsy[idx] !== 1'b1) || (rdy[idx] !== 1'b0)) begin
      errors++;
      $display("FAIL handshake_flags inst=%0d: busy=%b ready=%b, required busy=1 ready=0",
               idx, bsy[idx], rdy[idx]);
    end
    busy_cnt = (bsy[idx] === 1'b1) ? 1 : 0;
    if (!keep) vld[idx] = 1'b0;
    if (change) din[idx] = d_late;
    for (int j = 0; j < len; j++) begin
      @(negedge clk);
      e = expected_bit(idx, d, j / CD[idx]);
      checks++;
      if (tx[idx] !== e) begin
        errors++;
        $display("FAIL tx_bit inst=%0d data=%02h cycle=%0d: tx=%b, required %b", idx, d, j, tx[idx], e);
      end
      if (j < len - 1) begin
        if (bsy[idx] === 1'b1) busy_cnt++;
        checks++;
        if (rdy[idx] !== 1'b0) begin
          errors++;
          $display("FAIL ready_in_frame inst=%0d cycle=%0d: ready=%b, required 0", idx, j, rdy[idx]);
        end
      end else begin
        checks++;
        if ((bsy[idx] !== 1'b0) || (rdy[idx] !== 1'b1)) begin
          errors++;
          $display("FAIL idle_entry inst=%0d: busy=%b ready=%b, required busy=0 ready=1",
                   idx, bsy[idx], rdy[idx]);
        end
      end
    end
    checks++;
    if (busy_cnt != len) begin
      errors++;
      $display("FAIL frame_len inst=%0d: busy cycles=%0d, required %0d", idx, busy_cnt, len);
    end
  endtask

  task automatic check_idle_all(input string name, input logic exp_rdy);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if ((tx[i] !== 1'b1) || (bsy[i] !== 1'b0) || (rdy[i] !== exp_rdy)) begin
        errors++;
        $display("FAIL %s inst=%0d: tx=%b busy=%b ready=%b, required tx=1 busy=0 ready=%b",
                 name, i, tx[i], bsy[i], rdy[i], exp_rdy);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < NI; i++) din[i] = 8'h00;
    repeat (3) @(negedge clk);
    check_idle_all("reset_state", 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check_idle_all("ready_first_edge", 1'b0);
    @(negedge clk);
    check_idle_all("ready_second_edge", 1'b1);
  endtask

  task automatic test_basic();
    send(0, 8'hA5, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_parity();
    send(1, 8'hA5, 1'b0, 1'b0, 8'h00);
    send(2, 8'hA5, 1'b0, 1'b0, 8'h00);
    send(1, 8'h07, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_back_to_back();
    send(0, 8'h00, 1'b1, 1'b0, 8'h00);
    send(0, 8'hFF, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_data_stability();
    send(0, 8'h3C, 1'b0, 1'b1, 8'hC3);
  endtask

  task automatic test_reset_midframe();
    int w;
    din[0] = 8'h00;
    vld[0] = 1'b1;
    w = 0;
    while ((rdy[0] !== 1'b1) && (w < 100)) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    vld[0] = 1'b0;
    // Land in the first cycle of data bit 3 (frame position 4).
    repeat (4 * CD[0] + 1) @(negedge clk);
    checks++;
    if ((tx[0] !== 1'b0) || (bsy[0] !== 1'b1)) begin
      errors++;
      $display("FAIL midframe_before_reset: tx=%b busy=%b, required tx=0 busy=1", tx[0], bsy[0]);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ((tx[0] !== 1'b1) || (bsy[0] !== 1'b0) || (rdy[0] !== 1'b0)) begin
      errors++;
      $display("FAIL async_reset: tx=%b busy=%b ready=%b, required tx=1 busy=0 ready=0",
               tx[0], bsy[0], rdy[0]);
    end
    repeat (2) @(negedge clk);
    check_idle_all("held_reset", 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check_idle_all("release_first_edge", 1'b0);
    @(negedge clk);
    check_idle_all("release_second_edge", 1'b1);
    send(0, 8'h5A, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_stop2();
    send(3, 8'h81, 1'b1, 1'b0, 8'h00);
    send(3, 8'h42, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_random();
    int         idx;
    logic [7:0] d1;
    logic [7:0] d2;
    for (int n = 0; n < 8; n++) begin
      idx = int'($urandom_range(0, NI - 1));
      d1  = 8'($urandom);
      d2  = 8'($urandom);
      send(idx, d1, 1'b1, 1'b0, 8'h00);
      send(idx, d2, 1'b0, 1'b0, 8'h00);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_data_stability();
    test_reset_midframe();
    test_stop2();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
